ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Fetch PC owner + DEPTH-entry instruction queue to ID; word visible 2 cycles after request (1 with IFETCH_QUEUE_BYPASS_EN).
// Backpressure: id_ready low lets the queue fill, then imem_req drops until count+inflight < DEPTH; redirect/reset flush.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pcplus4,
    input  logic        id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          flush;
    logic [CW-1:0] occupancy;
    logic          q_vld;
    logic [63:0]   head;
    logic [63:0]   push_dat;
    logic          push;
    logic          pop;

    assign flush     = reset | redirect;
    // Reserving a slot for the in-flight word means a push can never find the queue full.
    assign occupancy = count + CW'(inflight);
    assign imem_req  = !flush && (occupancy < CW'(DEPTH));
    assign imem_addr = fetch_pc >> 2;
    assign q_vld     = (count != '0);
    assign head      = mem[rd_ptr];
    assign push_dat  = {imem_rdata, inflight_pc + 32'd4};

    always_comb begin
        id_valid   = 1'b0;
        id_instr   = '0;
        id_pcplus4 = '0;
        push       = 1'b0;
        pop        = 1'b0;
        if (!flush) begin
`ifdef IFETCH_QUEUE_BYPASS_EN
            if (inflight && !q_vld) begin
                // Empty queue: hand the returning word straight to decode; store it only if not taken.
                id_valid                 = 1'b1;
                {id_instr, id_pcplus4}   = push_dat;
                push                     = !id_ready;
            end else begin
                id_valid = q_vld;
                if (q_vld) begin
                    {id_instr, id_pcplus4} = head;
                end
                push = inflight;
                pop  = q_vld && id_ready;
            end
`else
            id_valid = q_vld;
            if (q_vld) begin
                {id_instr, id_pcplus4} = head;
            end
            push = inflight;
            pop  = q_vld && id_ready;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            fetch_pc    <= reset ? (RESET_PC & 32'hFFFF_FFFC) : (redirect_pc & 32'hFFFF_FFFC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized + directed bench for ifetch_queue against an architectural model of the decode stream.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pcplus4;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    // model: next PC decode must see, next PC fetch must request, words requested but not yet consumed
    logic [31:0] exp_pc;
    logic [31:0] fpc_m;
    int          outstanding;

    // per-cycle observations and model expectations
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc4;
    logic        e_pop;
    logic [31:0] e_instr, e_pc4, e_addr;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pcplus4 (id_pcplus4),
        .id_ready   (id_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // synchronous instruction memory; garbage when no read was issued
    always @(posedge clock) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
    end

    // Sample just before the rising edge, advance the model, then step to the next falling edge.
    task automatic tick();
        #1;
        s_req   = imem_req;
        s_valid = id_valid;
        s_addr  = imem_addr;
        s_instr = id_instr;
        s_pc4   = id_pcplus4;
        e_pop   = 1'b0;
        e_addr  = fpc_m >> 2;
        if (reset || redirect) begin
            exp_pc      = reset ? RESET_PC : (redirect_pc & ~32'h3);
            fpc_m       = exp_pc;
            outstanding = 0;
        end else begin
            if (s_valid && id_ready) begin
                e_pop   = 1'b1;
                e_instr = mem_word(exp_pc >> 2);
                e_pc4   = exp_pc + 32'd4;
                exp_pc  = exp_pc + 32'd4;
                outstanding--;
            end
            if (s_req) begin
                fpc_m = fpc_m + 32'd4;
                outstanding++;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        tick();
        tick();
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", s_req); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", s_valid); end
        total++; if (s_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", s_instr); end
        total++; if (s_pc4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h want=0", s_pc4); end
        total++; if (s_addr !== (RESET_PC >> 2)) begin bad++; $display("FAIL rst_addr got=%h want=%h", s_addr, RESET_PC >> 2); end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++; if (s_req !== 1'b1 || s_addr !== (RESET_PC >> 2) + c) begin
                bad++; $display("FAIL start_req c=%0d got=%0h/%h want=1/%h", c, s_req, s_addr, (RESET_PC >> 2) + c);
            end
            total++; if (s_valid !== (c >= LAT)) begin
                bad++; $display("FAIL start_valid c=%0d got=%0h want=%0h", c, s_valid, c >= LAT);
            end
            if (c >= LAT) begin
                total++; if (s_instr !== mem_word((RESET_PC >> 2) + c - LAT) || s_pc4 !== RESET_PC + 4 * (c - LAT + 1)) begin
                    bad++; $display("FAIL start_data c=%0d got=%h/%h want=%h/%h", c, s_instr, s_pc4,
                                    mem_word((RESET_PC >> 2) + c - LAT), RESET_PC + 4 * (c - LAT + 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        for (int i = 0; i < DEPTH + 6; i++) tick();
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL bp_req_low got=%0h want=0", s_req); end
        total++; if (outstanding != DEPTH) begin bad++; $display("FAIL bp_fill got=%0d want=%0d", outstanding, DEPTH); end
        id_ready = 1'b1;
        tick();
        total++; if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            bad++; $display("FAIL bp_release got=req%0h/vld%0h want=req0/vld1", s_req, s_valid);
        end
        tick();
        total++; if (s_req !== 1'b1) begin bad++; $display("FAIL bp_reissue got=%0h want=1", s_req); end
        for (int i = 0; i < 14; i++) begin
            if (e_pop) begin
                total++; if (s_instr !== e_instr || s_pc4 !== e_pc4) begin
                    bad++; $display("FAIL bp_stream got=%h/%h want=%h/%h", s_instr, s_pc4, e_instr, e_pc4);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        int first;
        first = -1;
        id_ready = 1'b0;
        tick();
        tick();
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rd_pre_valid got=%0h want=1", s_valid); end
        redirect = 1'b1; redirect_pc = 32'h0000_0203; id_ready = 1'b1;
        tick();
        total++; if (s_valid !== 1'b0 || s_req !== 1'b0 || s_instr !== 32'h0) begin
            bad++; $display("FAIL rd_cycle got=vld%0h/req%0h/%h want=0/0/0", s_valid, s_req, s_instr);
        end
        redirect = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                total++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin
                    bad++; $display("FAIL rd_first_req got=%0h/%h want=1/00000080", s_req, s_addr);
                end
            end
            if (s_valid && first < 0) begin
                first = k;
                total++; if (s_instr !== mem_word(32'h80) || s_pc4 !== 32'h0000_0204) begin
                    bad++; $display("FAIL rd_first_word got=%h/%h want=%h/00000204", s_instr, s_pc4, mem_word(32'h80));
                end
            end
            if (e_pop) begin
                total++; if (s_instr !== e_instr || s_pc4 !== e_pc4) begin
                    bad++; $display("FAIL rd_stream got=%h/%h want=%h/%h", s_instr, s_pc4, e_instr, e_pc4);
                end
            end
        end
        total++; if (first != LAT + 1) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", first, LAT + 1); end
    endtask

    task automatic test_redirect_pop();
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rp_pre_valid got=%0h want=1", s_valid); end
        redirect = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rp_cycle_valid got=%0h want=0", s_valid); end
        redirect = 1'b0;
        tick();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rp_empty got=%0h want=0", s_valid); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (e_pop) begin
                total++; if (s_instr !== e_instr || s_pc4 !== e_pc4) begin
                    bad++; $display("FAIL rp_stream got=%h/%h want=%h/%h", s_instr, s_pc4, e_instr, e_pc4);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want_i [3];
        logic [31:0] want_p [3];
        int n;
        want_i[0] = 32'h4FFF_FFFE; want_i[1] = 32'h4FFF_FFFF; want_i[2] = 32'h1000_0000;
        want_p[0] = 32'hFFFF_FFFC; want_p[1] = 32'h0000_0000; want_p[2] = 32'h0000_0004;
        n = 0;
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_valid && n < 3) begin
                total++; if (s_instr !== want_i[n] || s_pc4 !== want_p[n]) begin
                    bad++; $display("FAIL wrap_%0d got=%h/%h want=%h/%h", n, s_instr, s_pc4, want_i[n], want_p[n]);
                end
                n++;
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL wrap_count got=%0d want=3", n); end
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1; id_ready = 1'b1;
        tick();
        total++; if (s_req !== 1'b0 || s_valid !== 1'b0 || s_instr !== 32'h0 || s_pc4 !== 32'h0) begin
            bad++; $display("FAIL mid_rst got=req%0h/vld%0h/%h/%h want=0/0/0/0", s_req, s_valid, s_instr, s_pc4);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                total++; if (s_req !== 1'b1 || s_addr !== (RESET_PC >> 2) || s_valid !== 1'b0) begin
                    bad++; $display("FAIL mid_restart got=req%0h/%h/vld%0h want=1/%h/0", s_req, s_addr, s_valid, RESET_PC >> 2);
                end
            end
            if (s_valid && first < 0) begin
                first = k;
                total++; if (s_instr !== mem_word(RESET_PC >> 2) || s_pc4 !== RESET_PC + 32'd4) begin
                    bad++; $display("FAIL mid_first got=%h/%h want=%h/%h", s_instr, s_pc4, mem_word(RESET_PC >> 2), RESET_PC + 32'd4);
                end
            end
        end
        total++; if (first != LAT) begin bad++; $display("FAIL mid_latency got=%0d want=%0d", first, LAT); end
    endtask

    task automatic test_random();
        int npop;
        logic was_redirect;
        npop = 0;
        for (int i = 0; i < 800; i++) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom;
            was_redirect = redirect;
            tick();
            if (was_redirect) begin
                total++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin
                    bad++; $display("FAIL rnd_redirect i=%0d got=vld%0h/req%0h want=0/0", i, s_valid, s_req);
                end
            end
            if (e_pop) begin
                npop++;
                total++; if (s_instr !== e_instr || s_pc4 !== e_pc4) begin
                    bad++; $display("FAIL rnd_stream i=%0d got=%h/%h want=%h/%h", i, s_instr, s_pc4, e_instr, e_pc4);
                end
            end
            if (s_req) begin
                total++; if (s_addr !== e_addr) begin
                    bad++; $display("FAIL rnd_addr i=%0d got=%h want=%h", i, s_addr, e_addr);
                end
            end
            if (!s_valid) begin
                total++; if (s_instr !== 32'h0 || s_pc4 !== 32'h0) begin
                    bad++; $display("FAIL rnd_idle_zero i=%0d got=%h/%h want=0/0", i, s_instr, s_pc4);
                end
            end
            total++; if (outstanding < 0 || outstanding > DEPTH) begin
                bad++; $display("FAIL rnd_occupancy i=%0d got=%0d want=0..%0d", i, outstanding, DEPTH);
            end
        end
        redirect = 1'b0;
        total++; if (npop < 150) begin bad++; $display("FAIL rnd_throughput got=%0d want>=150", npop); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        exp_pc = RESET_PC; fpc_m = RESET_PC; outstanding = 0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
